// File: rtl/mbox_seq.sv
// mbox_seq: memory-box sequencer between the EBOX request lines and a
// synchronous backing RAM with fixed read latency. Runs read, write and
// read-pause-write cycles. AC references are served from a local 16-word file.
//
// Handshake: req is sampled only in IDLE. mboxBusy is high from the edge after
// req until the final ack cycle. mboxAck is a one-cycle pulse. In that cycle,
// cacheData is valid for a read, or the write has completed. A paused
// read-pause-write keeps mboxBusy high and raises pseWait until write arrives.
module mbox_seq #(
    parameter int ADDR_WIDTH  = 23,
    parameter int DATA_WIDTH  = 36,
    parameter int MEM_LATENCY = 2,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [ADDR_WIDTH-1:0] vma_i,
    input  logic                  vmaACRef_i,
    input  logic                  req_i,
    input  logic                  read_i,
    input  logic                  write_i,
    input  logic                  PSE_i,
    input  logic [DATA_WIDTH-1:0] writeData_i,
    output logic [DATA_WIDTH-1:0] cacheData_o,
    output logic                  mboxBusy_o,
    output logic                  mboxAck_o,
    output logic                  pseWait_o,
    output logic                  opErr_o,
    output logic [ADDR_WIDTH-1:0] memAddr_o,
    output logic [DATA_WIDTH-1:0] memWrData_o,
    output logic                  memEn_o,
    output logic                  memWe_o,
    input  logic [DATA_WIDTH-1:0] memRdData_i
);

    typedef enum logic [2:0] {
        IDLE, AC_OP, MEM_RD, RD_WAIT, PSE_HOLD, MEM_WR, WR_WAIT, ACK
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  acref_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  is_wr_q;
    logic                  pse_q;      // a pause follows the next ack
    logic                  operr_q;
    logic [DATA_WIDTH-1:0] cache_q;
    logic [DATA_WIDTH-1:0] ac_q [16];

    logic dec_pse, dec_wr, start_ok, start_err, accept;
    logic rd_done;

    // Decode the request lines into an operation and an error flag.
    always_comb begin
        dec_pse   = read_i & PSE_i;
        dec_wr    = ~dec_pse & write_i;
        start_ok  = read_i | write_i;
        start_err = (read_i & write_i & ~PSE_i) | ~(read_i | write_i);
        accept    = (state_q == IDLE) && req_i && start_ok;
        rd_done   = (state_q == RD_WAIT) && (cnt_q == 3'd0);
    end

    // State and wait-counter registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. Each counter is reloaded on entry to its wait state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_i && start_ok)
                    state_d = vmaACRef_i ? AC_OP : (dec_wr ? MEM_WR : MEM_RD);
            end
            AC_OP:  state_d = ACK;
            MEM_RD: begin
                state_d = RD_WAIT;
                cnt_d   = 3'(MEM_LATENCY - 1);
            end
            RD_WAIT: begin
                if (cnt_q == 3'd0) state_d = ACK;
                else               cnt_d   = cnt_q - 3'd1;
            end
            MEM_WR: begin
                state_d = WR_WAIT;
                cnt_d   = 3'(WAIT_STATES);
            end
            WR_WAIT: begin
                if (cnt_q == 3'd0) state_d = ACK;
                else               cnt_d   = cnt_q - 3'd1;
            end
            ACK:      state_d = pse_q ? PSE_HOLD : IDLE;
            PSE_HOLD: if (write_i) state_d = acref_q ? AC_OP : MEM_WR;
            default:  state_d = IDLE;
        endcase
    end

    // Request latches. The pause turns the cycle into a write on new data.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_q  <= '0;
            acref_q <= 1'b0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            pse_q   <= 1'b0;
            operr_q <= 1'b0;
        end else begin
            operr_q <= (state_q == IDLE) && req_i && start_err;
            if (accept) begin
                addr_q  <= vma_i;
                acref_q <= vmaACRef_i;
                wdata_q <= writeData_i;
                is_wr_q <= dec_wr;
                pse_q   <= dec_pse;
            end else if (state_q == PSE_HOLD && write_i) begin
                wdata_q <= writeData_i;
                is_wr_q <= 1'b1;
                pse_q   <= 1'b0;
            end
        end
    end

    // Read-data capture from either the AC file or the RAM.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cache_q <= '0;
        end else if (state_q == AC_OP && !is_wr_q) begin
            cache_q <= ac_q[addr_q[3:0]];
        end else if (rd_done) begin
            cache_q <= memRdData_i;
        end
    end

    // Fast-AC file writes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 16; i++) ac_q[i] <= '0;
        end else if (state_q == AC_OP && is_wr_q) begin
            ac_q[addr_q[3:0]] <= wdata_q;
        end
    end

    // Outputs decoded from state. Busy drops with the final ack.
    always_comb begin
        cacheData_o = cache_q;
        mboxAck_o   = (state_q == ACK);
        mboxBusy_o  = (state_q != IDLE) && !((state_q == ACK) && !pse_q);
        pseWait_o   = (state_q == PSE_HOLD);
        opErr_o     = operr_q;
        memAddr_o   = addr_q;
        memWrData_o = wdata_q;
        memEn_o     = (state_q == MEM_RD) || (state_q == MEM_WR);
        memWe_o     = (state_q == MEM_WR);
    end

endmodule

// File: tb/tb_mbox_seq.sv
// Testbench for mbox_seq: directed requests with an ack scoreboard,
// a RAM-write scoreboard and a behavioural RAM with two-cycle read latency.
module tb_mbox_seq;
  localparam int AW = 23;
  localparam int DW = 36;
  localparam int LAT = 2;
  localparam int WS = 1;

  logic clk, rst;
  logic [AW-1:0] vma;
  logic vma_ac, req, rd, wr, pse;
  logic [DW-1:0] wdata, cache_data, mem_wr_data, mem_rd_data;
  logic busy, ack, pse_wait, op_err, mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  mbox_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .WAIT_STATES(WS)) dut (
    .clk_i(clk), .reset_i(rst), .vma_i(vma), .vmaACRef_i(vma_ac), .req_i(req),
    .read_i(rd), .write_i(wr), .PSE_i(pse), .writeData_i(wdata),
    .cacheData_o(cache_data), .mboxBusy_o(busy), .mboxAck_o(ack),
    .pseWait_o(pse_wait), .opErr_o(op_err), .memAddr_o(mem_addr),
    .memWrData_o(mem_wr_data), .memEn_o(mem_en), .memWe_o(mem_we),
    .memRdData_i(mem_rd_data)
  );

  // clock / reset / cycle count
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural RAM, data valid LAT edges after the memEn edge
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] rd_p0, rd_p1;
  initial begin
    rd_p0 = '0;
    rd_p1 = '0;
  end
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] = mem_wr_data;
    if (mem_en && !mem_we) rd_p0 <= mem.exists(mem_addr) ? mem[mem_addr] : '0;
    else rd_p0 <= 36'h5a5a5a5a5;
    rd_p1 <= rd_p0;
  end
  assign mem_rd_data = rd_p1;

  // scoreboard state
  typedef struct packed {
    logic [31:0]   cyc;
    logic [DW-1:0] data;
    logic          chk;
    logic          busy;
  } ack_t;
  ack_t exp_q[$];
  logic [AW+DW-1:0] exp_wr_q[$];
  int checks = 0, errors = 0;
  int en_cnt = 0, err_cnt = 0, exp_err_cnt = 0;
  ack_t mon_e;
  logic [AW+DW-1:0] mon_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // monitor: pops expectations whenever the DUT acks or writes the RAM
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_en) en_cnt++;
      if (op_err) err_cnt++;
      if (ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ack_unexpected at cycle %0d", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
          if (mon_e.chk) check("ack_data", 64'(cache_data), 64'(mon_e.data));
          check("ack_busy", 64'(busy), 64'(mon_e.busy));
        end
      end
      if (mem_en && mem_we) begin
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected at cycle %0d addr %0h", cyc, mem_addr);
        end else begin
          mon_w = exp_wr_q.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(mon_w[AW+DW-1:DW]));
          check("wr_data", 64'(mem_wr_data), 64'(mon_w[DW-1:0]));
        end
      end
    end
  end

  // driver: called at a negedge, returns the edge number that sampled req
  task automatic issue(input logic ac, input logic r, input logic w, input logic p,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, output int unsigned n);
    vma_ac = ac; rd = r; wr = w; pse = p; vma = a; wdata = d; req = 1'b1;
    @(negedge clk);
    n = cyc;
    req = 1'b0; rd = 1'b0; wr = 1'b0; pse = 1'b0; vma_ac = 1'b0;
  endtask

  task automatic push_ack(input int unsigned c, input logic [DW-1:0] d, input logic chk, input logic b);
    ack_t e;
    e.cyc = c; e.data = d; e.chk = chk; e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || ack || exp_q.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle_timeout", 64'(k >= 100), 64'd0);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cache"}, 64'(cache_data), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ack"}, 64'(ack), 64'd0);
    check({tag, "_psewait"}, 64'(pse_wait), 64'd0);
    check({tag, "_operr"}, 64'(op_err), 64'd0);
    check({tag, "_memen"}, 64'({mem_en, mem_we}), 64'd0);
    check({tag, "_memaddr"}, 64'(mem_addr), 64'd0);
    check({tag, "_memwrdata"}, 64'(mem_wr_data), 64'd0);
  endtask

  localparam logic [DW-1:0] RAM_WORD = 36'o777000111222;
  localparam logic [DW-1:0] AC_WORD  = 36'o123456701234;

  initial begin
    int unsigned n, m;
    int en0;
    rst = 1'b1; req = 1'b0; rd = 1'b0; wr = 1'b0; pse = 1'b0; vma_ac = 1'b0;
    vma = '0; wdata = '0;
    mem[23'h00300] = RAM_WORD;
    mem[23'h00200] = 36'd5;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // reset mid-read drops the cycle and clears the AC file
    issue(1'b1, 1'b0, 1'b1, 1'b0, 23'd3, 36'd7, n);
    push_ack(n + 1, '0, 1'b0, 1'b0);
    wait_idle();
    issue(1'b0, 1'b1, 1'b0, 1'b0, 23'h00300, '0, n);
    push_ack(n + 1 + LAT, RAM_WORD, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b1, 1'b1, 1'b0, 1'b0, 23'd3, '0, n);
    push_ack(n + 1, '0, 1'b1, 1'b0);
    wait_idle();

    // RAM read
    en0 = en_cnt;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 23'h00300, '0, n);
    push_ack(n + 1 + LAT, RAM_WORD, 1'b1, 1'b0);
    check("rd_strobe", 64'({mem_en, mem_we}), 64'b10);
    check("rd_addr", 64'(mem_addr), 64'h300);
    check("rd_busy", 64'(busy), 64'd1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("rd_cache_held", 64'(cache_data), 64'(RAM_WORD));
    check("rd_en_pulses", 64'(en_cnt - en0), 64'd1);

    // AC write and read-back, no RAM strobes
    en0 = en_cnt;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 23'h00005, AC_WORD, n);
    push_ack(n + 1, '0, 1'b0, 1'b0);
    wait_idle();
    issue(1'b1, 1'b1, 1'b0, 1'b0, 23'h00005, '0, n);
    push_ack(n + 1, AC_WORD, 1'b1, 1'b0);
    wait_idle();
    check("ac_no_memen", 64'(en_cnt - en0), 64'd0);

    // RAM write
    en0 = en_cnt;
    exp_wr_q.push_back({23'h00100, 36'd1});
    issue(1'b0, 1'b0, 1'b1, 1'b0, 23'h00100, 36'd1, n);
    push_ack(n + 2 + WS, AC_WORD, 1'b1, 1'b0);
    check("wr_strobe", 64'({mem_en, mem_we}), 64'b11);
    wait_idle();
    check("wr_en_pulses", 64'(en_cnt - en0), 64'd1);

    // read-pause-write
    issue(1'b0, 1'b1, 1'b0, 1'b1, 23'h00200, '0, n);
    push_ack(n + 1 + LAT, 36'd5, 1'b1, 1'b1);
    for (int k = 0; k < 20 && !pse_wait; k++) @(negedge clk);
    check("pse_wait_up", 64'(pse_wait), 64'd1);
    check("pse_busy_up", 64'(busy), 64'd1);
    en0 = en_cnt;
    for (int i = 0; i < 10; i++) begin
      req = i[0]; rd = 1'b1; vma = 23'h00007;
      @(negedge clk);
    end
    req = 1'b0; rd = 1'b0;
    check("pse_hold_quiet", 64'(en_cnt - en0), 64'd0);
    check("pse_hold_wait", 64'(pse_wait), 64'd1);
    exp_wr_q.push_back({23'h00200, 36'd6});
    wr = 1'b1; wdata = 36'd6;
    @(negedge clk);
    m = cyc;
    wr = 1'b0;
    push_ack(m + 2 + WS, 36'd5, 1'b1, 1'b0);
    check("pse_wait_drop", 64'(pse_wait), 64'd0);
    wait_idle();

    // error cases
    issue(1'b0, 1'b0, 1'b0, 1'b0, 23'h00010, '0, n);
    exp_err_cnt++;
    check("noop_operr", 64'(op_err), 64'd1);
    check("noop_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("noop_operr_pulse", 64'(op_err), 64'd0);
    check("noop_idle", 64'(busy), 64'd0);
    exp_wr_q.push_back({23'h00400, 36'd9});
    issue(1'b0, 1'b1, 1'b1, 1'b0, 23'h00400, 36'd9, n);
    exp_err_cnt++;
    push_ack(n + 2 + WS, 36'd5, 1'b1, 1'b0);
    check("rw_operr", 64'(op_err), 64'd1);
    wait_idle();
    issue(1'b0, 1'b1, 1'b0, 1'b0, 23'h00300, '0, n);
    push_ack(n + 1 + LAT, RAM_WORD, 1'b1, 1'b0);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 23'h00500, 36'd3, m);
    wait_idle();

    check("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
    check("operr_count", 64'(err_cnt), 64'(exp_err_cnt));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
